// File: rtl/ha_test_pkg.sv
// Shared definitions for the half-adder response checker and its bench:
// session states, default MISR polynomial and the golden half-adder function.
package ha_test_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] SIG_POLY_DEF = 8'h1D;

  function automatic logic [1:0] ha_expected(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/ha_resp_checker_if.sv
// Stimulus/response and verdict bundle between a half-adder test source
// (master) and ha_resp_checker (slave).
interface ha_resp_checker_if #(
  parameter int CNT_W = 8,
  parameter int SIG_W = 8
);

  logic             start;
  logic             in_valid;
  logic             a;
  logic             b;
  logic             sum;
  logic             carry;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] vec_count;
  logic [1:0]       first_fail;
  logic             fail_seen;
  logic [SIG_W-1:0] signature;

  modport master (
    output start, in_valid, a, b, sum, carry,
    input  busy, done, pass, err_count, vec_count, first_fail, fail_seen, signature
  );

  modport slave (
    input  start, in_valid, a, b, sum, carry,
    output busy, done, pass, err_count, vec_count, first_fail, fail_seen, signature
  );

endinterface

// File: rtl/ha_misr.sv
// Multiple-input signature register compacting {carry,sum} responses.
// Built only when HA_CHK_MISR_EN is defined.
module ha_misr #(
  parameter int               SIG_W    = 8,
  parameter logic [SIG_W-1:0] SIG_POLY = 8'h1D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_r;
  logic [SIG_W-1:0] sig_s;

  // Next signature: shift with polynomial feedback, fold response into low bits
  always_comb begin
    sig_s = {sig_r[SIG_W-2:0], 1'b0};
    if (sig_r[SIG_W-1]) begin
      sig_s = sig_s ^ SIG_POLY;
    end else begin
      sig_s = sig_s;
    end
    sig_s = sig_s ^ SIG_W'(din);
  end

  // Signature register; clear wins over step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_r <= {SIG_W{1'b0}};
    end else if (clr) begin
      sig_r <= {SIG_W{1'b0}};
    end else if (en) begin
      sig_r <= sig_s;
    end else begin
      sig_r <= sig_r;
    end
  end

  assign sig = sig_r;

endmodule

// File: rtl/ha_resp_checker.sv
// Half-adder response checker: compares DUT sum/carry against the golden
// function per session. Optional MISR compaction under HA_CHK_MISR_EN.
module ha_resp_checker
  import ha_test_pkg::*;
#(
  parameter int               NUM_VECTORS = 4,
  parameter int               CNT_W       = 8,
  parameter int               SIG_W       = 8,
  parameter logic [SIG_W-1:0] SIG_POLY    = SIG_W'(SIG_POLY_DEF)
) (
  input logic               clk,
  input logic               rst,
  ha_resp_checker_if.slave  chk
);

  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS - 1);

  state_e           state_r, state_s;
  logic             start_s, accept_s, mismatch_s, last_s;
  logic [CNT_W-1:0] err_count_r, err_count_s;
  logic [CNT_W-1:0] vec_count_r, vec_count_s;
  logic [1:0]       first_fail_r, first_fail_s;
  logic             fail_seen_r, fail_seen_s;
  logic             busy_r, done_r, pass_r;

  assign start_s    = chk.start && (state_r != RUN);
  assign accept_s   = chk.in_valid && (state_r == RUN);
  assign mismatch_s = ({chk.carry, chk.sum} != ha_expected(chk.a, chk.b));
  assign last_s     = (vec_count_r == LAST_VEC);

  // Session sequencing
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (chk.start) state_s = RUN;  else state_s = IDLE;
      RUN:     if (accept_s && last_s) state_s = DONE; else state_s = RUN;
      DONE:    if (chk.start) state_s = RUN;  else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Result updates; a start in IDLE/DONE clears and drops any coincident vector
  always_comb begin
    err_count_s  = err_count_r;
    vec_count_s  = vec_count_r;
    first_fail_s = first_fail_r;
    fail_seen_s  = fail_seen_r;
    if (start_s) begin
      err_count_s  = {CNT_W{1'b0}};
      vec_count_s  = {CNT_W{1'b0}};
      first_fail_s = 2'b00;
      fail_seen_s  = 1'b0;
    end else if (accept_s) begin
      vec_count_s = vec_count_r + CNT_W'(1);
      if (mismatch_s) begin
        if (err_count_r != {CNT_W{1'b1}}) begin
          err_count_s = err_count_r + CNT_W'(1);
        end else begin
          err_count_s = err_count_r;
        end
        if (!fail_seen_r) begin
          first_fail_s = {chk.a, chk.b};
          fail_seen_s  = 1'b1;
        end else begin
          first_fail_s = first_fail_r;
        end
      end else begin
        err_count_s = err_count_r;
      end
    end else begin
      vec_count_s = vec_count_r;
    end
  end

  // State and result registers; verdict flags registered from next-state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      err_count_r  <= {CNT_W{1'b0}};
      vec_count_r  <= {CNT_W{1'b0}};
      first_fail_r <= 2'b00;
      fail_seen_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      err_count_r  <= err_count_s;
      vec_count_r  <= vec_count_s;
      first_fail_r <= first_fail_s;
      fail_seen_r  <= fail_seen_s;
      busy_r       <= (state_s == RUN);
      done_r       <= (state_s == DONE);
      pass_r       <= (state_s == DONE) && (err_count_s == {CNT_W{1'b0}});
    end
  end

  assign chk.busy       = busy_r;
  assign chk.done       = done_r;
  assign chk.pass       = pass_r;
  assign chk.err_count  = err_count_r;
  assign chk.vec_count  = vec_count_r;
  assign chk.first_fail = first_fail_r;
  assign chk.fail_seen  = fail_seen_r;

`ifdef HA_CHK_MISR_EN
  logic [SIG_W-1:0] signature_s;

  ha_misr #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (start_s),
    .en  (accept_s),
    .din ({chk.carry, chk.sum}),
    .sig (signature_s)
  );

  assign chk.signature = signature_s;
`else
  logic unused_poly_s;
  assign unused_poly_s = ^SIG_POLY;
  assign chk.signature = {SIG_W{1'b0}};
`endif

endmodule

// File: doc/ha_resp_checker.md
# ha_resp_checker

Downstream response checker for the half adder stage. It takes each applied stimulus pair (a, b) together with the DUT's sum/carry response. It compares the response against the golden half-adder function, counts mismatches, latches the first failing vector, and optionally compacts responses into a MISR signature. Test sessions are bounded by a start/done handshake so that benches and on-chip BIST wrappers see one pass/fail verdict per run.

## Interface
- NUM_VECTORS, 4: vectors accepted per session (≥1).
- CNT_W, 8: width of vector and error counters.
- SIG_W, 8: MISR width (≥2).
- SIG_POLY, 8'h1D: MISR feedback polynomial, low SIG_W bits.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin session; sampled in IDLE or DONE.
- in_valid  in  1  a/b/sum/carry valid this cycle.
- a  in  1  stimulus bit a applied to DUT.
- b  in  1  stimulus bit b applied to DUT.
- sum  in  1  DUT sum response.
- carry  in  1  DUT carry response.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  done && err_count == 0.
- err_count  out  CNT_W  mismatching vectors; saturates at all-ones.
- vec_count  out  CNT_W  vectors accepted this session.
- first_fail  out  2  {a,b} of first mismatch; 2'b00 if none.
- fail_seen  out  1  at least one mismatch this session.
- signature  out  SIG_W  MISR state.

## Operation
- FSM: IDLE → RUN on start. RUN → DONE when the NUM_VECTORS-th vector is accepted. DONE → RUN on start. No other transitions.
- Entering RUN clears err_count, vec_count, first_fail, fail_seen and signature to 0.
- Accept: in_valid high in RUN. Expected response is exp_sum = a^b, exp_carry = a&b. Mismatch if either bit differs.
- On an accepted mismatch: err_count increments and saturates. On the first mismatch only, first_fail ← {a,b} and fail_seen ← 1.
- MISR step per accept: sig ← ({sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? SIG_POLY : 0)) ^ {carry,sum} in bits [1:0].
- in_valid outside RUN is ignored. start while in RUN is ignored.
- In DONE, all result outputs hold until the next start.

## Timing
- Reset: state IDLE. busy, done, pass, fail_seen = 0. err_count, vec_count, first_fail, signature = 0.
- Compare latency is 1 cycle. Results of a vector accepted at edge N are visible after edge N.
- The last accept and the RUN→DONE transition happen on the same edge. done and pass are valid the cycle after the last vector.
- start accepted at edge N gives busy = 1 and cleared results after edge N. A vector can be accepted from edge N+1.
- If start and in_valid are both high in IDLE or DONE, start wins and the vector is dropped.
- Reset asserted mid-session aborts the session immediately. No partial result is retained.

## Configuration
- HA_CHK_MISR_EN defined: the MISR is built and signature updates as specified.
- HA_CHK_MISR_EN undefined: no MISR logic. signature is tied to 0.
- Compare, counting and the FSM are identical in both builds.

## Structure
- Shared package ha_test_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default SIG_POLY constant;
  - a golden-model function ha_expected(a, b) returning {carry,sum}. The testbench reuses this function.
- One sub-module, ha_misr, holds the signature register and feedback. It is instantiated only under HA_CHK_MISR_EN.

## Test plan
- Reset, then idle 5 cycles: all outputs 0, state IDLE, in_valid pulses ignored (vec_count stays 0).
- start, then a good DUT with 00, 01, 10, 11 on consecutive cycles:
  - done = 1 the cycle after vector 11;
  - pass = 1, err_count = 0, vec_count = 4;
  - signature = 8'h04 (MISR build), 0 otherwise.
- carry stuck-at-0 on the same sequence: err_count = 1, first_fail = 2'b11, fail_seen = 1, pass = 0, signature = 8'h06.
- sum inverted on every vector: err_count = 4, first_fail = 2'b00.
- Restart after DONE: all results cleared the cycle after start. Then check the following two cases:
  - start while busy has no effect;
  - start and in_valid in the same cycle drops the vector (vec_count = 0).
- Assert rst after 2 vectors: all outputs 0 on the next sample and state IDLE. A fresh run then passes normally.
